// File: rtl/lsu_pkg.sv
// Shared definitions for the byte-serial load/store sequencer:
// active-low mem_op bit positions, FSM states, access size codes and op decode.
package lsu_pkg;

  localparam int OP_LB  = 7;
  localparam int OP_LH  = 6;
  localparam int OP_LW  = 5;
  localparam int OP_LBU = 4;
  localparam int OP_LHU = 3;
  localparam int OP_SB  = 2;
  localparam int OP_SH  = 1;
  localparam int OP_SW  = 0;

  localparam logic [7:0] MEM_OP_NONE = 8'hFF;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2
  } size_e;

  typedef struct packed {
    logic       illegal;
    logic       is_load;
    logic       is_unsigned;
    logic [1:0] size;
  } op_dec_t;

  // Decode the active-low one-hot op bus; anything but exactly one low bit is illegal.
  function automatic op_dec_t decode_op(input logic [7:0] mem_op);
    op_dec_t    d;
    logic [7:0] act;
    logic [3:0] cnt;
    act = ~mem_op;
    cnt = 4'd0;
    for (int i = 0; i < 8; i++) begin
      cnt = cnt + {3'd0, act[i]};
    end
    d.illegal     = (cnt != 4'd1);
    d.is_load     = act[OP_LB] | act[OP_LH] | act[OP_LW] | act[OP_LBU] | act[OP_LHU];
    d.is_unsigned = act[OP_LBU] | act[OP_LHU];
    if (act[OP_LW] | act[OP_SW]) begin
      d.size = SZ_W;
    end else if (act[OP_LH] | act[OP_LHU] | act[OP_SH]) begin
      d.size = SZ_H;
    end else begin
      d.size = SZ_B;
    end
    return d;
  endfunction

  // Index of the final beat for a given size (beats are 1/2/4).
  function automatic logic [1:0] last_idx(input logic [1:0] sz);
    logic [1:0] r;
    case (sz)
      SZ_B:    r = 2'd0;
      SZ_H:    r = 2'd1;
      SZ_W:    r = 2'd3;
      default: r = 2'd0;
    endcase
    return r;
  endfunction

  // Halfwords need even addresses, words need 4-byte alignment.
  function automatic logic misaligned(input logic [1:0] sz, input logic [1:0] lo);
    logic r;
    case (sz)
      SZ_H:    r = lo[0];
      SZ_W:    r = |lo;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/lsu_extend.sv
// Sign/zero extension of the assembled little-endian load value.
module lsu_extend
  import lsu_pkg::*;
(
  input  logic [31:0] raw,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  output logic [31:0] ext
);

  // Widen byte/halfword loads according to signedness; words pass through.
  always_comb begin
    ext = raw;
    case (size)
      SZ_B:    ext = is_unsigned ? {24'd0, raw[7:0]}  : {{24{raw[7]}}, raw[7:0]};
      SZ_H:    ext = is_unsigned ? {16'd0, raw[15:0]} : {{16{raw[15]}}, raw[15:0]};
      SZ_W:    ext = raw;
      default: ext = raw;
    endcase
  end

endmodule

// File: rtl/lsu_seq8.sv
// Load/store sequencer: turns one lb/lh/lw/lbu/lhu/sb/sh/sw request into
// 1/2/4 little-endian byte beats on an 8-bit ready-handshaked bus.
module lsu_seq8
  import lsu_pkg::*;
#(
  parameter int AW       = 32,
  parameter int MAX_WAIT = 15
)
(
  input  logic          clk,
  input  logic          rst,
  input  logic          req,
  input  logic [7:0]    mem_op,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata,
  output logic          busy,
  output logic          done,
  output logic          fault,
  output logic          bus_err,
  output logic [AW-1:0] bus_addr,
  output logic [7:0]    bus_wdata,
  input  logic [7:0]    bus_rdata,
  output logic          bus_re,
  output logic          bus_we,
  input  logic          bus_ready
);

  // The counter compares against MAX_WAIT-1 because it counts completed wait cycles.
  localparam logic [15:0] WAIT_LIM_C = (MAX_WAIT > 0) ? 16'(MAX_WAIT - 1) : 16'd0;

  state_e        state_r;
  logic [AW-1:0] addr_r;
  logic [31:0]   wdata_r;
  logic          load_r;
  logic          uns_r;
  logic [1:0]    size_r;
  logic [1:0]    last_r;
  logic [1:0]    idx_r;
  logic [15:0]   wait_r;
  logic [31:0]   rbuf_r;
  logic [31:0]   rdata_r;
  logic          done_r;
  logic          fault_r;
  logic          bus_err_r;
  logic [AW-1:0] bus_addr_r;
  logic [7:0]    bus_wdata_r;
  logic          bus_re_r;
  logic          bus_we_r;

  op_dec_t       dec_s;
  logic          accept_s;
  logic          bad_s;
  logic          beat_s;
  logic          timeout_s;
  logic [1:0]    idx_nx_s;
  logic [31:0]   raw_s;
  logic [31:0]   ext_s;

  // Classify the incoming request while idle.
  always_comb begin
    dec_s = decode_op(mem_op);
    if ((state_r == S_IDLE) && req && (mem_op != MEM_OP_NONE)) begin
      accept_s = 1'b1;
    end else begin
      accept_s = 1'b0;
    end
    bad_s = dec_s.illegal | misaligned(dec_s.size, addr[1:0]);
  end

  // Beat completion, wait-limit detection and next byte index.
  always_comb begin
    beat_s    = (bus_re_r | bus_we_r) & bus_ready;
    timeout_s = (MAX_WAIT != 0) && (wait_r == WAIT_LIM_C);
    idx_nx_s  = idx_r + 2'd1;
  end

  // Merge the byte arriving this cycle so the final value is ready at the last beat.
  always_comb begin
    raw_s = rbuf_r;
    if (bus_re_r && bus_ready) begin
      raw_s[{idx_r, 3'b000} +: 8] = bus_rdata;
    end else begin
      raw_s = rbuf_r;
    end
  end

  lsu_extend u_extend (
    .raw         (raw_s),
    .size        (size_r),
    .is_unsigned (uns_r),
    .ext         (ext_s)
  );

  // Sequencer FSM, latches, counters and registered bus/status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= S_IDLE;
      addr_r      <= '0;
      wdata_r     <= 32'd0;
      load_r      <= 1'b0;
      uns_r       <= 1'b0;
      size_r      <= SZ_B;
      last_r      <= 2'd0;
      idx_r       <= 2'd0;
      wait_r      <= 16'd0;
      rbuf_r      <= 32'd0;
      rdata_r     <= 32'd0;
      done_r      <= 1'b0;
      fault_r     <= 1'b0;
      bus_err_r   <= 1'b0;
      bus_addr_r  <= '0;
      bus_wdata_r <= 8'd0;
      bus_re_r    <= 1'b0;
      bus_we_r    <= 1'b0;
    end else begin
      done_r    <= 1'b0;
      fault_r   <= 1'b0;
      bus_err_r <= 1'b0;
      case (state_r)
        S_IDLE: begin
          if (accept_s) begin
            addr_r  <= addr;
            wdata_r <= wdata;
            load_r  <= dec_s.is_load;
            uns_r   <= dec_s.is_unsigned;
            size_r  <= dec_s.size;
            last_r  <= last_idx(dec_s.size);
            idx_r   <= 2'd0;
            wait_r  <= 16'd0;
            rbuf_r  <= 32'd0;
            if (bad_s) begin
              state_r <= S_DONE;
              done_r  <= 1'b1;
              fault_r <= 1'b1;
            end else begin
              state_r     <= S_ACCESS;
              bus_addr_r  <= addr;
              bus_wdata_r <= wdata[7:0];
              bus_re_r    <= dec_s.is_load;
              bus_we_r    <= ~dec_s.is_load;
            end
          end else begin
            state_r <= S_IDLE;
          end
        end
        S_ACCESS: begin
          if (beat_s) begin
            rbuf_r <= raw_s;
            wait_r <= 16'd0;
            if (idx_r == last_r) begin
              state_r  <= S_DONE;
              done_r   <= 1'b1;
              bus_re_r <= 1'b0;
              bus_we_r <= 1'b0;
              if (load_r) begin
                rdata_r <= ext_s;
              end else begin
                rdata_r <= rdata_r;
              end
            end else begin
              idx_r       <= idx_nx_s;
              bus_addr_r  <= addr_r + {{(AW-2){1'b0}}, idx_nx_s};
              bus_wdata_r <= wdata_r[{idx_nx_s, 3'b000} +: 8];
            end
          end else if (timeout_s) begin
            state_r   <= S_DONE;
            done_r    <= 1'b1;
            bus_err_r <= 1'b1;
            bus_re_r  <= 1'b0;
            bus_we_r  <= 1'b0;
          end else begin
            wait_r <= wait_r + 16'd1;
          end
        end
        S_DONE: begin
          state_r <= S_IDLE;
        end
        default: begin
          state_r  <= S_IDLE;
          bus_re_r <= 1'b0;
          bus_we_r <= 1'b0;
        end
      endcase
    end
  end

  assign busy      = accept_s | (state_r == S_ACCESS);
  assign rdata     = rdata_r;
  assign done      = done_r;
  assign fault     = fault_r;
  assign bus_err   = bus_err_r;
  assign bus_addr  = bus_addr_r;
  assign bus_wdata = bus_wdata_r;
  assign bus_re    = bus_re_r;
  assign bus_we    = bus_we_r;

endmodule

// File: tb/tb_lsu_seq8.sv
// Directed self-checking bench for lsu_seq8 with a byte-memory bus responder
// and a transaction-level model of the expected result.
module tb_lsu_seq8;

  localparam int MW = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        req;
  logic [7:0]  mem_op;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        busy;
  logic        done;
  logic        fault;
  logic        bus_err;
  logic [31:0] bus_addr;
  logic [7:0]  bus_wdata;
  logic [7:0]  bus_rdata;
  logic        bus_re;
  logic        bus_we;
  logic        bus_ready;

  int checks   = 0;
  int failures = 0;

  logic [7:0]  mem [0:4095];
  logic [31:0] exp_rdata;

  always #5 clk = ~clk;

  lsu_seq8 #(.AW(32), .MAX_WAIT(MW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .mem_op    (mem_op),
    .addr      (addr),
    .wdata     (wdata),
    .rdata     (rdata),
    .busy      (busy),
    .done      (done),
    .fault     (fault),
    .bus_err   (bus_err),
    .bus_addr  (bus_addr),
    .bus_wdata (bus_wdata),
    .bus_rdata (bus_rdata),
    .bus_re    (bus_re),
    .bus_we    (bus_we),
    .bus_ready (bus_ready)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req_v);
    checks++;
    if (act !== req_v) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req_v);
    end
  endtask

  // Transaction-level model: legality, beat count and load result from the op rules.
  task automatic model(input logic [7:0] op, input logic [31:0] a,
                       output bit flt, output int n, output bit ld, output logic [31:0] val);
    int cnt;
    int sel;
    logic [31:0] t;
    cnt = 0; sel = -1; flt = 1'b0; n = 0; ld = 1'b0; val = 32'd0;
    for (int b = 0; b < 8; b++) if (!op[b]) begin cnt++; sel = b; end
    if (cnt != 1) begin flt = 1'b1; return; end
    case (sel)
      7, 4, 2: n = 1;
      6, 3, 1: n = 2;
      default: n = 4;
    endcase
    ld = (sel >= 3);
    if ((int'(a[1:0]) % n) != 0) begin flt = 1'b1; return; end
    if (ld) begin
      for (int i = 0; i < n; i++) begin
        t = a + i;
        val = val | ({24'd0, mem[t[11:0]]} << (8 * i));
      end
      if (sel == 7 && val[7])  val = val | 32'hFFFFFF00;
      if (sel == 6 && val[15]) val = val | 32'hFFFF0000;
    end
  endtask

  // Issue one request, act as the bus slave, and check every cycle until done.
  task automatic run_op(input string tag, input logic [7:0] op, input logic [31:0] a,
                        input logic [31:0] wd, input int wait0, input bit stuck,
                        input bit lit_en, input logic [31:0] lit_rdata, input int lit_done);
    bit flt, ld, got;
    int n, beat, waited, cyc, exp_done;
    logic [31:0] val;
    model(op, a, flt, n, ld, val);
    exp_done = flt ? 1 : (stuck ? 1 + MW : n + 1 + wait0);
    @(negedge clk);
    req = 1'b1; mem_op = op; addr = a; wdata = wd;
    #1;
    chk({tag, "_busy_accept"}, {31'd0, busy}, 32'd1);
    @(posedge clk);
    #1;
    req = 1'b0; mem_op = 8'h7F; addr = ~a; wdata = ~wd;
    beat = 0; waited = 0; got = 1'b0; cyc = 0;
    while (cyc < 40 && !got) begin
      @(negedge clk);
      cyc++;
      bus_ready = 1'b0;
      if (bus_re || bus_we) begin
        chk({tag, "_beat_legal"}, {31'd0, (!flt && beat < n)}, 32'd1);
        chk({tag, "_bus_addr"}, bus_addr, a + beat);
        chk({tag, "_bus_re"}, {31'd0, bus_re}, {31'd0, ld});
        chk({tag, "_bus_we"}, {31'd0, bus_we}, {31'd0, !ld});
        if (!ld) chk({tag, "_bus_wdata"}, {24'd0, bus_wdata}, {24'd0, wd[8*beat +: 8]});
        if (!stuck && !(beat == 0 && waited < wait0)) begin
          bus_ready = 1'b1;
          bus_rdata = mem[bus_addr[11:0]];
          if (bus_we) mem[bus_addr[11:0]] = bus_wdata;
          beat++;
        end else begin
          bus_rdata = 8'h5A;
          waited++;
        end
      end
      if (done) begin
        got = 1'b1;
        if (ld && !flt && !stuck) exp_rdata = val;
        chk({tag, "_done_cycle"}, cyc, exp_done);
        chk({tag, "_busy_done"}, {31'd0, busy}, 32'd0);
        chk({tag, "_fault"}, {31'd0, fault}, {31'd0, flt});
        chk({tag, "_bus_err"}, {31'd0, bus_err}, {31'd0, (!flt && stuck)});
        chk({tag, "_rdata"}, rdata, exp_rdata);
        chk({tag, "_strobes_done"}, {30'd0, bus_re, bus_we}, 32'd0);
        chk({tag, "_beats"}, beat, (flt || stuck) ? 0 : n);
        chk({tag, "_done_lit"}, cyc, lit_done);
        if (lit_en) chk({tag, "_rdata_lit"}, rdata, lit_rdata);
      end else begin
        chk({tag, "_busy_access"}, {31'd0, busy}, 32'd1);
      end
    end
    if (!got) chk({tag, "_done_timeout"}, 32'd0, 32'd1);
    @(negedge clk);
    bus_ready = 1'b0;
    chk({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
    chk({tag, "_rdata_hold"}, rdata, exp_rdata);
  endtask

  initial begin
    bit seen;
    rst = 1'b1; req = 1'b0; mem_op = 8'hFF; addr = 32'd0; wdata = 32'd0;
    bus_rdata = 8'd0; bus_ready = 1'b0; exp_rdata = 32'd0;
    for (int i = 0; i < 4096; i++) mem[i] = 8'd0;
    mem[12'h100] = 8'h78; mem[12'h101] = 8'h56; mem[12'h102] = 8'h34; mem[12'h103] = 8'h12;
    mem[12'h201] = 8'h80; mem[12'h202] = 8'hFE; mem[12'h203] = 8'hFF;
    mem[12'h050] = 8'h9C;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_outputs", {rdata[7:0], 16'd0, busy, done, fault, bus_err, bus_re, bus_we, 2'd0},
        32'd0);
    chk("reset_bus_addr", bus_addr, 32'd0);
    chk("reset_rdata", rdata, 32'd0);

    // req with no op is ignored
    req = 1'b1; mem_op = 8'hFF;
    #1;
    chk("none_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    req = 1'b0;
    chk("none_no_done", {31'd0, done}, 32'd0);
    @(negedge clk);
    chk("none_no_strobe", {30'd0, bus_re, bus_we}, 32'd0);

    run_op("lw",    8'hDF, 32'h100, 32'd0, 0, 1'b0, 1'b1, 32'h12345678, 5);
    run_op("lb",    8'h7F, 32'h201, 32'd0, 0, 1'b0, 1'b1, 32'hFFFFFF80, 2);
    run_op("lbu",   8'hEF, 32'h201, 32'd0, 0, 1'b0, 1'b1, 32'h00000080, 2);
    run_op("lhu",   8'hF7, 32'h202, 32'd0, 0, 1'b0, 1'b1, 32'h0000FFFE, 3);
    run_op("lh",    8'hBF, 32'h202, 32'd0, 0, 1'b0, 1'b1, 32'hFFFFFFFE, 3);
    run_op("sh",    8'hFD, 32'h010, 32'hAABBCCDD, 3, 1'b0, 1'b1, 32'hFFFFFFFE, 6);
    chk("sh_mem0", {24'd0, mem[12'h010]}, 32'h000000DD);
    chk("sh_mem1", {24'd0, mem[12'h011]}, 32'h000000CC);
    chk("sh_mem2", {24'd0, mem[12'h012]}, 32'h00000000);
    run_op("sw",    8'hFE, 32'h020, 32'hCAFEF00D, 0, 1'b0, 1'b0, 32'd0, 5);
    run_op("lw_rb", 8'hDF, 32'h020, 32'd0, 0, 1'b0, 1'b1, 32'hCAFEF00D, 5);
    run_op("sb",    8'hFB, 32'h033, 32'h000000A5, 1, 1'b0, 1'b0, 32'd0, 3);
    chk("sb_mem", {24'd0, mem[12'h033]}, 32'h000000A5);
    run_op("lw_mis",  8'hDF, 32'h102, 32'd0, 0, 1'b0, 1'b1, 32'hCAFEF00D, 1);
    run_op("sh_mis",  8'hFD, 32'h007, 32'h1234, 0, 1'b0, 1'b1, 32'hCAFEF00D, 1);
    run_op("multi",   8'hFC, 32'h040, 32'd0, 0, 1'b0, 1'b1, 32'hCAFEF00D, 1);
    run_op("timeout", 8'h7F, 32'h300, 32'd0, 0, 1'b1, 1'b1, 32'hCAFEF00D, 5);

    // reset in the middle of a word store
    @(negedge clk);
    req = 1'b1; mem_op = 8'hFE; addr = 32'h40; wdata = 32'h11223344;
    @(posedge clk);
    #1;
    req = 1'b0; mem_op = 8'hFF;
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      bus_ready = 1'b1;
      if (bus_we && bus_addr == 32'h42) seen = 1'b1;
    end
    chk("rst_reached_beat2", {31'd0, seen}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus_ready = 1'b0;
    chk("rst_strobes", {30'd0, bus_re, bus_we}, 32'd0);
    chk("rst_busy_done", {30'd0, busy, done}, 32'd0);
    chk("rst_bus_addr", bus_addr, 32'd0);
    chk("rst_bus_wdata", {24'd0, bus_wdata}, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    exp_rdata = 32'd0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("rst_no_done", {31'd0, done}, 32'd0);
    end
    run_op("lbu_after_rst", 8'hEF, 32'h050, 32'd0, 0, 1'b0, 1'b1, 32'h0000009C, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
